// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounced push-button input slot.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        WAIT1   = 2'd1,
        STABLE1 = 2'd2,
        WAIT0   = 2'd3
    } db_state_e;

    localparam logic [1:0] REG_LEVEL = 2'd0;
    localparam logic [1:0] REG_EVENT = 2'd1;
    localparam logic [1:0] REG_DBMS  = 2'd2;
    localparam logic [1:0] REG_RAW   = 2'd3;

    localparam int RISE_LSB = 0;
    localparam int FALL_LSB = 16;

endpackage

// File: rtl/debounce_input_core_channel.sv
// One debounce channel: a stable/wait FSM with a tick-driven down-counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DB_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            sync_in,
    input  logic [DB_W-1:0] db_ms,
    output logic            level,
    output logic            rise,
    output logic            fall
);

    db_state_e       state;
    logic [DB_W-1:0] cnt;

    // The interval is sampled only on WAIT entry, so db_ms writes never disturb a wait in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STABLE0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                STABLE0: begin
                    if (sync_in) begin
                        state <= WAIT1;
                        cnt   <= db_ms;
                    end
                end
                WAIT1: begin
                    if (!sync_in) begin
                        state <= STABLE0;
                    end else if (cnt == '0) begin
                        state <= STABLE1;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt - DB_W'(1);
                    end
                end
                STABLE1: begin
                    if (!sync_in) begin
                        state <= WAIT0;
                        cnt   <= db_ms;
                    end
                end
                WAIT0: begin
                    if (sync_in) begin
                        state <= STABLE1;
                    end else if (cnt == '0) begin
                        state <= STABLE0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt - DB_W'(1);
                    end
                end
                default: state <= STABLE0;
            endcase
        end
    end

endmodule

// File: rtl/debounce_input_core.sv
// Slot core: synchronizes and debounces N buttons, latches edge events,
// exposes levels/events/interval/raw over the 32-bit slot bus.
module debounce_input_core
    import debounce_pkg::*;
#(
    parameter int N          = 4,
    parameter int TICK_DIV   = 100000,
    parameter int DB_W       = 8,
    parameter int DB_DEFAULT = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [N-1:0] btn_in,
    output logic         irq
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [N-1:0]    sync1;
    logic [N-1:0]    sync2;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [DB_W-1:0] db_ms;
    logic [N-1:0]    level;
    logic [N-1:0]    rise_p;
    logic [N-1:0]    fall_p;
    logic [N-1:0]    rise_flags;
    logic [N-1:0]    fall_flags;
    logic [N-1:0]    rise_clr;
    logic [N-1:0]    fall_clr;
    logic            wr_en;
    logic            unused;

    assign unused = ^{read, addr[4:2], wr_data};
    assign wr_en  = write && cs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_ms <= DB_W'(DB_DEFAULT);
        end else if (wr_en && addr[1:0] == REG_DBMS) begin
            db_ms <= wr_data[DB_W-1:0];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DB_W(DB_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .sync_in(sync2[i]),
            .db_ms  (db_ms),
            .level  (level[i]),
            .rise   (rise_p[i]),
            .fall   (fall_p[i])
        );
    end

    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        if (wr_en && addr[1:0] == REG_EVENT) begin
            rise_clr = wr_data[RISE_LSB +: N];
            fall_clr = wr_data[FALL_LSB +: N];
        end
    end

    // A new edge in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_flags <= '0;
            fall_flags <= '0;
            irq        <= 1'b0;
        end else begin
            rise_flags <= (rise_flags & ~rise_clr) | rise_p;
            fall_flags <= (fall_flags & ~fall_clr) | fall_p;
            irq        <= |{rise_flags, fall_flags};
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (addr[1:0])
            REG_LEVEL: rd_data[N-1:0] = level;
            REG_EVENT: begin
                rd_data[RISE_LSB +: N] = rise_flags;
                rd_data[FALL_LSB +: N] = fall_flags;
            end
            REG_DBMS:  rd_data[DB_W-1:0] = db_ms;
            REG_RAW:   rd_data[N-1:0] = sync2;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_debounce_input_core.sv
// Directed bench for debounce_input_core with a 10-cycle tick and 3 ms default.
module tb_debounce_input_core;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  btn_in;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    debounce_input_core #(
        .N         (4),
        .TICK_DIV  (10),
        .DB_W      (8),
        .DB_DEFAULT(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .btn_in (btn_in),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = {3'b000, a};
        #1;
        d = rd_data;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = {3'b000, a};
        wr_data = d;
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    logic [31:0] d;
    logic        found;

    initial begin
        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        btn_in  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        rd(0, d); check("rst_level", d, 32'h0);
        rd(1, d); check("rst_event", d, 32'h0);
        rd(2, d); check("rst_dbms", d, 32'h3);
        rd(3, d); check("rst_raw", d, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // channel 0 press
        @(negedge clk);
        btn_in[0] = 1'b1;
        @(negedge clk);
        rd(3, d); check("raw0_1clk", d, 32'h0);
        @(negedge clk);
        rd(3, d); check("raw0_2clk", d, 32'h1);
        repeat (15) @(negedge clk);
        rd(0, d); check("lvl0_early", d, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            rd(0, d);
            if (d[0]) found = 1'b1;
        end
        check("lvl0_rise_seen", {31'b0, found}, 32'h1);
        rd(1, d); check("evt_before_set", d, 32'h0);
        check("irq_before_set", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rd(1, d); check("evt_rise0", d, 32'h1);
        check("irq_lag", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise0", {31'b0, irq}, 32'h1);

        // short glitch on channel 1
        btn_in[1] = 1'b1;
        repeat (15) @(negedge clk);
        btn_in[1] = 1'b0;
        repeat (40) @(negedge clk);
        rd(0, d); check("glitch_level", d, 32'h1);
        rd(1, d); check("glitch_event", d, 32'h1);

        // clear rise0 in the very cycle fall0 is being set
        btn_in[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            rd(0, d);
            if (!d[0]) found = 1'b1;
        end
        check("lvl0_fall_seen", {31'b0, found}, 32'h1);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = 5'd1;
        wr_data = 32'h0001_0001;
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
        rd(1, d); check("set_wins", d, 32'h0001_0000);
        check("irq_held", {31'b0, irq}, 32'h1);
        wr(1, 32'h0001_0000);
        rd(1, d); check("evt_cleared", d, 32'h0);
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // zero interval on channel 2, and read-only level register
        wr(0, 32'hF);
        rd(0, d); check("level_ro", d, 32'h0);
        wr(2, 32'h0);
        rd(2, d); check("dbms_zero", d, 32'h0);
        btn_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        rd(0, d); check("ch2_rise_pre", d, 32'h0);
        @(negedge clk);
        rd(0, d); check("ch2_rise", d, 32'h4);
        btn_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        rd(0, d); check("ch2_fall_pre", d, 32'h4);
        @(negedge clk);
        rd(0, d); check("ch2_fall", d, 32'h0);
        @(negedge clk);
        rd(1, d); check("ch2_events", d, 32'h0004_0004);
        @(negedge clk);
        check("ch2_irq", {31'b0, irq}, 32'h1);
        wr(1, 32'hFFFF_FFFF);
        wr(2, 32'h3);
        rd(1, d); check("clear_all", d, 32'h0);

        // reset in the middle of a channel 3 wait
        btn_in[3] = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        rd(0, d); check("midrst_level", d, 32'h0);
        rd(1, d); check("midrst_event", d, 32'h0);
        rd(3, d); check("midrst_raw", d, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        rd(0, d); check("restart_pre", d, 32'h0);
        rd(1, d); check("restart_noevt", d, 32'h0);
        @(negedge clk);
        rd(0, d); check("restart_commit", d, 32'h8);
        @(negedge clk);
        rd(1, d); check("restart_evt", d, 32'h8);
        check("restart_irq_lag", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("restart_irq", {31'b0, irq}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
